// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: pc_sel encodings, fetch FSM states, datapath widths.
// IF_ALIGN_CHECK_EN adds the HALT state used by the misaligned-target fault.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_REL = 2'b01;
    localparam logic [1:0] PCSEL_REG = 2'b10;

`ifdef IF_ALIGN_CHECK_EN
    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        FETCH      = 2'd1,
        EXEC       = 2'd2,
        HALT       = 2'd3
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        FETCH      = 2'd1,
        EXEC       = 2'd2
    } fetch_state_t;
`endif

endpackage

// File: rtl/if_next_pc.sv
// Next-PC selection: sequential, PC-relative word offset or register target.
// Arithmetic wraps modulo 2^64; misaligned flags a target with nonzero low bits.
module if_next_pc
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        pc_sel,
    input  logic [ADDR_W-1:0] offset,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misaligned
);

    always_comb begin
        case (pc_sel)
            PCSEL_REL: next_pc = pc + (offset << 2);
            PCSEL_REG: next_pc = reg_target;
            default:   next_pc = pc + 64'd4;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: holds PC, handshakes with instruction memory, presents one instruction at a time.
// IF_ALIGN_CHECK_EN: misaligned next PC halts with fault; otherwise low PC bits are forced to 00.
//
// state      | meaning
// RESET_WAIT | first cycle after reset, no request yet
// FETCH      | mem_req high at pc, waiting for mem_ack
// EXEC       | instruction held for control unit until instr_done
// HALT       | misaligned target trapped, left only by reset (align-check build)
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          pc_sel,
    input  logic [ADDR_W-1:0]   offset,
    input  logic [ADDR_W-1:0]   reg_target,
    input  logic                instr_done,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [INSTR_W-1:0]  mem_rdata,
    output logic [INSTR_W-1:0]  instruction,
    output logic                instr_valid,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   pc_plus4,
    output logic                fault
);

    fetch_state_t       state, state_d;
    logic [ADDR_W-1:0]  pc_d;
    logic [INSTR_W-1:0] instr_d;
    logic               valid_d;
    logic [ADDR_W-1:0]  next_pc;
    logic               misaligned;

    if_next_pc u_next_pc (
        .pc         (pc),
        .pc_sel     (pc_sel),
        .offset     (offset),
        .reg_target (reg_target),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

`ifdef IF_ALIGN_CHECK_EN
    logic fault_q, fault_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) fault_q <= 1'b0;
        else        fault_q <= fault_d;
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= RESET_WAIT;
            pc          <= RESET_PC;
            instruction <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            instruction <= instr_d;
            instr_valid <= valid_d;
        end
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        instr_d = instruction;
        valid_d = instr_valid;
        mem_req = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        fault_d = fault_q;
`endif
        case (state)
            RESET_WAIT: state_d = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    instr_d = mem_rdata;
                    valid_d = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (instr_done) begin
                    valid_d = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
                    if (misaligned) begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
`else
                    pc_d    = misaligned ? {next_pc[ADDR_W-1:2], 2'b00} : next_pc;
                    state_d = FETCH;
`endif
                end
            end
`ifdef IF_ALIGN_CHECK_EN
            HALT: state_d = HALT;
`endif
            default: state_d = RESET_WAIT;
        endcase
    end

    // mem_req decodes straight from state so an async reset drops it at once
    assign mem_addr = pc;
    assign pc_plus4 = pc + 64'd4;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with an expected-fetch-address scoreboard.
// Compile with IF_ALIGN_CHECK_EN to exercise the HALT/fault path.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic [63:0] offset = '0;
    logic [63:0] reg_target = '0;
    logic        instr_done = 1'b0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic        fault;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_pc;
    logic [31:0] cur_instr;

    instruction_fetch #(.RESET_PC(64'h100)) dut (
        .clock       (clock),
        .reset       (reset),
        .pc_sel      (pc_sel),
        .offset      (offset),
        .reg_target  (reg_target),
        .instr_done  (instr_done),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fault       (fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(output logic [63:0] addr);
        int n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("mem_req_timeout", {63'd0, mem_req}, 64'd1);
        addr = 64'hX;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty: observed fetch at %h expected no fetch", mem_addr);
        end else begin
            addr = exp_q.pop_front();
            check("mem_addr", mem_addr, addr);
        end
        check("valid_in_fetch", {63'd0, instr_valid}, 64'd0);
    endtask

    task automatic fetch_ack(input logic [31:0] data, input int waits);
        logic [63:0] a;
        wait_req(a);
        for (int i = 0; i < waits; i++) begin
            instr_done = 1'b1;
            mem_rdata  = $urandom;
            @(negedge clock);
            check("req_hold", {63'd0, mem_req}, 64'd1);
            check("addr_hold", mem_addr, a);
            check("pc_hold_stray_done", pc, exp_pc);
        end
        instr_done = 1'b0;
        mem_ack    = 1'b1;
        mem_rdata  = data;
        @(posedge clock);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        cur_instr = data;
        check("instruction", {32'd0, instruction}, {32'd0, data});
        check("valid_after_ack", {63'd0, instr_valid}, 64'd1);
        check("req_drop_exec", {63'd0, mem_req}, 64'd0);
    endtask

    task automatic exec_idle();
        @(negedge clock);
        mem_ack    = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        pc_sel     = 2'b10;
        reg_target = 64'h1234;
        @(negedge clock);
        mem_ack = 1'b0;
        check("instr_frozen", {32'd0, instruction}, {32'd0, cur_instr});
        check("pc_frozen", pc, exp_pc);
        check("pc_plus4", pc_plus4, exp_pc + 64'd4);
        check("valid_exec", {63'd0, instr_valid}, 64'd1);
        check("req_exec", {63'd0, mem_req}, 64'd0);
    endtask

    task automatic exec_done(input logic [1:0] sel, input logic [63:0] off,
                             input logic [63:0] tgt, input logic [63:0] nxt);
        exec_idle();
        instr_done = 1'b1;
        pc_sel     = sel;
        offset     = off;
        reg_target = tgt;
        @(posedge clock);
        #1;
        instr_done = 1'b0;
        pc_sel     = 2'b01;
        offset     = 64'h55;
        check("next_pc", pc, nxt);
        check("valid_cleared", {63'd0, instr_valid}, 64'd0);
        exp_pc = nxt;
        exp_q.push_back(nxt);
    endtask

    task automatic reset_mid_fetch();
        logic [63:0] a;
        wait_req(a);
        #2 reset = 1'b0;
        #1;
        check("req_async_drop", {63'd0, mem_req}, 64'd0);
        check("pc_reset", pc, 64'h100);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        @(posedge clock);
        #1;
        mem_ack = 1'b0;
        check("resp_discarded", {32'd0, instruction}, 64'd0);
        check("valid_reset", {63'd0, instr_valid}, 64'd0);
        @(negedge clock);
        reset  = 1'b1;
        exp_pc = 64'h100;
        exp_q.push_back(64'h100);
        fetch_ack(32'h91000421, 1);
    endtask

    initial begin
        #12;
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_valid", {63'd0, instr_valid}, 64'd0);
        check("rst_instruction", {32'd0, instruction}, 64'd0);
        check("rst_pc", pc, 64'h100);
        check("rst_fault", {63'd0, fault}, 64'd0);
        @(negedge clock);
        reset  = 1'b1;
        exp_pc = 64'h100;
        exp_q.push_back(64'h100);

        fetch_ack(32'h8B020020, 0);
        exec_done(2'b00, 64'h0, 64'h0, 64'h104);
        fetch_ack(32'h8B020020, 0);
        exec_done(2'b11, 64'h7, 64'h0, 64'h108);
        fetch_ack(32'h8B020020, 0);
        exec_done(2'b10, 64'h0, 64'h200, 64'h200);
        fetch_ack(32'h14000001, 0);
        exec_done(2'b01, -64'sd2, 64'h0, 64'h1F8);
        fetch_ack(32'hAA0103E0, 3);
        exec_done(2'b10, 64'h0, 64'h0, 64'h0);
        fetch_ack(32'h17FFFFFF, 0);
        exec_done(2'b01, -64'sd1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch_ack(32'hD61F0000, 2);
        exec_done(2'b10, 64'h0, 64'h4000, 64'h4000);
        fetch_ack(32'hD61F0020, 0);

`ifdef IF_ALIGN_CHECK_EN
        exec_idle();
        instr_done = 1'b1;
        pc_sel     = 2'b10;
        reg_target = 64'h4002;
        @(posedge clock);
        #1;
        instr_done = 1'b0;
        check("halt_fault", {63'd0, fault}, 64'd1);
        check("halt_pc", pc, 64'h4000);
        check("halt_valid", {63'd0, instr_valid}, 64'd0);
        mem_ack = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("halt_req", {63'd0, mem_req}, 64'd0);
            check("halt_fault_hold", {63'd0, fault}, 64'd1);
        end
        mem_ack = 1'b0;
        reset = 1'b0;
        #1;
        check("fault_reset", {63'd0, fault}, 64'd0);
        @(negedge clock);
        reset  = 1'b1;
        exp_pc = 64'h100;
        exp_q.push_back(64'h100);
`else
        exec_done(2'b10, 64'h0, 64'h4002, 64'h4000);
        check("fault_tied", {63'd0, fault}, 64'd0);
`endif
        reset_mid_fetch();
        exec_done(2'b00, 64'h0, 64'h0, 64'h104);
        fetch_ack(32'h8B020020, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
